// File: rtl/sort_fuc_pkg.sv
// Shared widths, FSM state and row-buffer entry type for the counting sorter.
// Width localparams are derived from the sorter-level configuration constants.
package sort_fuc_pkg;
    localparam int SORT_FUC_MAX_NUM    = 1024;
    localparam int SORT_FUC_BK_NUM     = 4;
    localparam int SORT_FUC_REPEAT_NUM = 16;
    localparam int SORT_PRU_BUF_DEPTH  = 4;

    localparam int CNT_W  = $clog2(SORT_FUC_REPEAT_NUM);
    localparam int BK_W   = $clog2(SORT_FUC_BK_NUM);
    localparam int DEPTH  = SORT_FUC_MAX_NUM / SORT_FUC_BK_NUM;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int ROW_W  = CNT_W * SORT_FUC_BK_NUM;
    localparam int VAL_W  = $clog2(SORT_FUC_MAX_NUM);
    localparam int FCNT_W = $clog2(SORT_PRU_BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        PRU_IDLE,
        PRU_SCAN,
        PRU_DRAIN,
        PRU_DONE
    } pru_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
    } pru_row_t;

    function automatic logic [CNT_W-1:0] bank_cnt(input logic [ROW_W-1:0] row,
                                                  input logic [BK_W-1:0]  bk);
        return row[bk*CNT_W +: CNT_W];
    endfunction
endpackage

// File: rtl/sort_pru_row_fifo.sv
// Row buffer between the count-memory read return and the expander.
// Pushes into a full FIFO are dropped and flagged by an assertion.
module sort_pru_row_fifo
    import sort_fuc_pkg::*;
#(
    parameter int WIDTH = $bits(pru_row_t),
    parameter int N_ENT = SORT_PRU_BUF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              head,
    output logic                          empty,
    output logic [$clog2(N_ENT+1)-1:0]    cnt
);
    localparam int PTR_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int CW    = $clog2(N_ENT + 1);

    logic [WIDTH-1:0] mem [N_ENT];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign full    = (cnt == CW'(N_ENT));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_ENT-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // The issue credit must keep returns from ever landing on a full buffer.
    no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/sort_pru_unit.sv
// Pop/readout unit: scans and clears every count row, expands bank counts into a sorted stream.
// Define SORT_PRU_ZERO_SKIP_EN to jump over zero banks in the same cycle instead of stepping.
module sort_pru_unit
    import sort_fuc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl2pru_start_i,
    input  logic              cntu2ctrl_wr_done_vld_i,
    output logic              pru2ctrl_busy_o,
    output logic              pru2ctrl_done_o,
    output logic              pru2cnt_rd_vld_o,
    output logic [ADDR_W-1:0] pru2cnt_rd_addr_o,
    input  logic              cnt2pru_rd_vld_i,
    input  logic [ADDR_W-1:0] cnt2pru_rd_addr_i,
    input  logic [ROW_W-1:0]  cnt2pru_rd_data_i,
    output logic              pru2out_vld_o,
    output logic [VAL_W-1:0]  pru2out_data_o,
    input  logic              out2pru_rdy_i
);
    pru_state_t        state, state_nxt;
    logic [ADDR_W-1:0] scan_ptr;
    logic [1:0]        outstanding;
    logic [FCNT_W:0]   inflight;
    logic [FCNT_W-1:0] fifo_cnt;
    logic              issue, ret, pop, fifo_empty;
    pru_row_t          ret_row, head;

    logic [BK_W-1:0]   bk_ptr, eff_bk;
    logic [CNT_W-1:0]  rep, cur_cnt;
    logic              rep_vld, nz_found, exp_act, out_vld, fire, bank_done;

    // Credit counts both rows in flight and rows already buffered.
    assign inflight = (FCNT_W+1)'(outstanding) + (FCNT_W+1)'(fifo_cnt);
    assign issue    = (state == PRU_SCAN) && (inflight < (FCNT_W+1)'(SORT_PRU_BUF_DEPTH));
    assign ret      = cnt2pru_rd_vld_i && (state != PRU_IDLE) && (outstanding != 2'd0);
    assign ret_row  = '{addr: cnt2pru_rd_addr_i, data: cnt2pru_rd_data_i};

    sort_pru_row_fifo u_row_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret),
        .din   (ret_row),
        .pop   (pop),
        .head  (head),
        .empty (fifo_empty),
        .cnt   (fifo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PRU_IDLE;
            scan_ptr    <= '0;
            outstanding <= '0;
        end else begin
            state <= state_nxt;
            if (state == PRU_IDLE) scan_ptr <= '0;
            else if (issue)        scan_ptr <= scan_ptr + 1'b1;
            case ({issue, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        pru2ctrl_busy_o  = (state != PRU_IDLE);
        pru2ctrl_done_o  = (state == PRU_DONE);
        pru2cnt_rd_vld_o = issue;
        case (state)
            PRU_IDLE:  if (ctrl2pru_start_i && cntu2ctrl_wr_done_vld_i) state_nxt = PRU_SCAN;
            PRU_SCAN:  if (issue && scan_ptr == ADDR_W'(DEPTH-1)) state_nxt = PRU_DRAIN;
            // Looks through the pop of the last entry so done follows the final beat by one cycle.
            PRU_DRAIN: if (outstanding == 2'd0 &&
                           (fifo_empty || (fifo_cnt == FCNT_W'(1) && pop))) state_nxt = PRU_DONE;
            PRU_DONE:  state_nxt = PRU_IDLE;
            default:   state_nxt = PRU_IDLE;
        endcase
    end

    assign pru2cnt_rd_addr_o = scan_ptr;

`ifdef SORT_PRU_ZERO_SKIP_EN
    // Lowest nonzero bank at or above bk_ptr; none found means the row is spent.
    always_comb begin
        nz_found = 1'b0;
        eff_bk   = bk_ptr;
        for (int i = SORT_FUC_BK_NUM-1; i >= 0; i--) begin
            if (i >= int'(bk_ptr) && bank_cnt(head.data, BK_W'(i)) != '0) begin
                nz_found = 1'b1;
                eff_bk   = BK_W'(i);
            end
        end
    end
`else
    assign nz_found = 1'b1;
    assign eff_bk   = bk_ptr;
`endif

    assign exp_act   = !fifo_empty;
    assign cur_cnt   = rep_vld ? rep : bank_cnt(head.data, eff_bk);
    assign out_vld   = exp_act && nz_found && (cur_cnt != '0);
    assign fire      = out_vld && out2pru_rdy_i;
    assign bank_done = exp_act && (!nz_found || cur_cnt == '0 || (fire && cur_cnt == CNT_W'(1)));
    assign pop       = bank_done && (!nz_found || eff_bk == BK_W'(SORT_FUC_BK_NUM-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bk_ptr  <= '0;
            rep     <= '0;
            rep_vld <= 1'b0;
        end else if (bank_done) begin
            rep_vld <= 1'b0;
            bk_ptr  <= pop ? '0 : eff_bk + 1'b1;
        end else if (fire) begin
            rep     <= cur_cnt - 1'b1;
            rep_vld <= 1'b1;
            bk_ptr  <= eff_bk;
        end
    end

    assign pru2out_vld_o  = out_vld;
    assign pru2out_data_o = out_vld ? {head.addr, eff_bk} : '0;
endmodule

// File: tb/tb_sort_pru_unit.sv
// Directed bench for sort_pru_unit with a 2-cycle read-and-clear count-memory model.
module tb_sort_pru_unit;
    import sort_fuc_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ctrl2pru_start_i = 1'b0;
    logic              cntu2ctrl_wr_done_vld_i = 1'b1;
    logic              pru2ctrl_busy_o, pru2ctrl_done_o;
    logic              pru2cnt_rd_vld_o;
    logic [ADDR_W-1:0] pru2cnt_rd_addr_o;
    logic              cnt2pru_rd_vld_i = 1'b0;
    logic [ADDR_W-1:0] cnt2pru_rd_addr_i = '0;
    logic [ROW_W-1:0]  cnt2pru_rd_data_i = '0;
    logic              pru2out_vld_o;
    logic [VAL_W-1:0]  pru2out_data_o;
    logic              out2pru_rdy_i = 1'b1;

    always #5 clk = ~clk;

    sort_pru_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .ctrl2pru_start_i        (ctrl2pru_start_i),
        .cntu2ctrl_wr_done_vld_i (cntu2ctrl_wr_done_vld_i),
        .pru2ctrl_busy_o         (pru2ctrl_busy_o),
        .pru2ctrl_done_o         (pru2ctrl_done_o),
        .pru2cnt_rd_vld_o        (pru2cnt_rd_vld_o),
        .pru2cnt_rd_addr_o       (pru2cnt_rd_addr_o),
        .cnt2pru_rd_vld_i        (cnt2pru_rd_vld_i),
        .cnt2pru_rd_addr_i       (cnt2pru_rd_addr_i),
        .cnt2pru_rd_data_i       (cnt2pru_rd_data_i),
        .pru2out_vld_o           (pru2out_vld_o),
        .pru2out_data_o          (pru2out_data_o),
        .out2pru_rdy_i           (out2pru_rdy_i)
    );

    // Count memory: read-and-clear, data returned two cycles after the request.
    logic [ROW_W-1:0]  mem [DEPTH];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [ROW_W-1:0]  ld_data = '0;
    logic              s1_vld = 1'b0;
    logic [ADDR_W-1:0] s1_addr = '0;
    logic [ROW_W-1:0]  s1_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        s1_vld  <= pru2cnt_rd_vld_o;
        s1_addr <= pru2cnt_rd_addr_o;
        s1_data <= mem[pru2cnt_rd_addr_o];
        if (pru2cnt_rd_vld_o) mem[pru2cnt_rd_addr_o] <= '0;
        cnt2pru_rd_vld_i  <= s1_vld;
        cnt2pru_rd_addr_i <= s1_addr;
        cnt2pru_rd_data_i <= s1_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output / request monitor, sampled on the falling edge.
    logic [VAL_W-1:0] beats[$];
    int               rd_cnt, done_cnt, addr_err, stall_err, last_beat_cyc, done_cyc;
    logic             stalled;
    logic [VAL_W-1:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            if (pru2out_vld_o && out2pru_rdy_i) begin
                beats.push_back(pru2out_data_o);
                last_beat_cyc = cyc;
            end
            if (pru2cnt_rd_vld_o) begin
                if (pru2cnt_rd_addr_o != ADDR_W'(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            if (pru2ctrl_done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stalled && !(pru2out_vld_o && pru2out_data_o == held)) stall_err++;
            stalled = pru2out_vld_o && !out2pru_rdy_i;
            held    = pru2out_data_o;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int a, input int d);
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(a);
        ld_data = ROW_W'(d);
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic clr_mon();
        beats.delete();
        rd_cnt = 0; done_cnt = 0; addr_err = 0; stall_err = 0;
        last_beat_cyc = 0; done_cyc = 0; stalled = 1'b0; held = '0;
    endtask

    int start_cyc;
    task automatic pulse_start();
        ctrl2pru_start_i = 1'b1;
        start_cyc = cyc;
        tick();
        ctrl2pru_start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no done within %0d cycles", nm, budget);
        end
        tick(2);
    endtask

    typedef struct {
        int row;
        int data;
        int nbeats;
        int first;
        int last;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [VAL_W-1:0] exp_q[$];
        logic [ROW_W-1:0] d;
        int mism, n;

        vt[0] = '{3,   'h0102, 3,  12,   14};
        vt[1] = '{255, 'hF000, 15, 1023, 1023};
        vt[2] = '{0,   'h1111, 4,  0,    3};
        vt[3] = '{128, 'h0030, 3,  513,  513};
        vt[4] = '{77,  'h0000, 0,  0,    0};

        clr_mon();
        for (int i = 0; i < DEPTH; i++) load(i, 0);
        chk("rst busy",    int'(pru2ctrl_busy_o),   0);
        chk("rst done",    int'(pru2ctrl_done_o),   0);
        chk("rst rd_vld",  int'(pru2cnt_rd_vld_o),  0);
        chk("rst rd_addr", int'(pru2cnt_rd_addr_o), 0);
        chk("rst out_vld", int'(pru2out_vld_o),     0);
        chk("rst out_dat", int'(pru2out_data_o),    0);
        rst = 1'b0;
        tick(2);

        // start without wr_done is ignored
        cntu2ctrl_wr_done_vld_i = 1'b0;
        pulse_start();
        tick();
        chk("gated start busy", int'(pru2ctrl_busy_o), 0);
        chk("gated start reads", rd_cnt, 0);
        cntu2ctrl_wr_done_vld_i = 1'b1;

        for (int v = 0; v < 5; v++) begin
            load(vt[v].row, vt[v].data);
            clr_mon();
            out2pru_rdy_i = 1'b1;
            pulse_start();
            chk("busy after start", int'(pru2ctrl_busy_o), 1);
            wait_done("vec done", 3000);
            chk("vec beats", beats.size(), vt[v].nbeats);
            if (vt[v].nbeats > 0 && beats.size() > 0) begin
                chk("vec first", int'(beats[0]), vt[v].first);
                chk("vec last",  int'(beats[beats.size()-1]), vt[v].last);
            end
            d = ROW_W'(vt[v].data);
            exp_q.delete();
            for (int b = 0; b < SORT_FUC_BK_NUM; b++)
                repeat (int'(d[b*CNT_W +: CNT_W]))
                    exp_q.push_back(VAL_W'(vt[v].row * SORT_FUC_BK_NUM + b));
            mism = (exp_q.size() == beats.size()) ? 0 : 1;
            if (mism == 0)
                for (int i = 0; i < beats.size(); i++) if (beats[i] != exp_q[i]) mism++;
            chk("vec stream", mism, 0);
            chk("vec reads", rd_cnt, DEPTH);
            chk("vec addr order", addr_err, 0);
            chk("vec done pulses", done_cnt, 1);
            chk("vec idle after", int'(pru2ctrl_busy_o), 0);
            if (vt[v].row == DEPTH-1 && vt[v].nbeats > 0)
                chk("done after last beat", done_cyc - last_beat_cyc, 1);
            if (vt[v].nbeats == 0) begin
                chk("zero mem no beats", beats.size(), 0);
`ifdef SORT_PRU_ZERO_SKIP_EN
                chk_rng("zero mem done cyc", done_cyc - start_cyc, 256, 266);
`else
                chk_rng("zero mem done cyc", done_cyc - start_cyc, 1020, 1040);
`endif
            end
        end

        // backpressure: rows 0..7 all ones, consumer stalled 20 cycles
        for (int r = 0; r < 8; r++) load(r, 'h1111);
        clr_mon();
        out2pru_rdy_i = 1'b0;
        pulse_start();
        tick(20);
        chk("bp reads in stall", rd_cnt, SORT_PRU_BUF_DEPTH);
        chk("bp vld held", int'(pru2out_vld_o), 1);
        chk("bp data held", int'(pru2out_data_o), 0);
        out2pru_rdy_i = 1'b1;
        wait_done("bp done", 3000);
        mism = (beats.size() == 32) ? 0 : 1;
        if (mism == 0)
            for (int i = 0; i < 32; i++) if (int'(beats[i]) != i) mism++;
        chk("bp stream", mism, 0);
        chk("bp stability", stall_err, 0);
        chk("bp reads", rd_cnt, DEPTH);

        // reset mid-scan: row 50 is read before reset, row 200 only after restart
        load(50, 'h0001);
        load(200, 'h0001);
        clr_mon();
        pulse_start();
        n = 0;
        while (!(pru2cnt_rd_vld_o && pru2cnt_rd_addr_o == ADDR_W'(100)) && n < 2000) begin
            tick();
            n++;
        end
        chk("reach row 100", int'(pru2cnt_rd_vld_o && pru2cnt_rd_addr_o == ADDR_W'(100)), 1);
        chk("pre-reset beat", beats.size() > 0 ? int'(beats[0]) : -1, 200);
        rst = 1'b1;
        tick();
        chk("mid rst busy",    int'(pru2ctrl_busy_o),   0);
        chk("mid rst rd_vld",  int'(pru2cnt_rd_vld_o),  0);
        chk("mid rst rd_addr", int'(pru2cnt_rd_addr_o), 0);
        chk("mid rst out_vld", int'(pru2out_vld_o),     0);
        chk("mid rst out_dat", int'(pru2out_data_o),    0);
        chk("mid rst done",    int'(pru2ctrl_done_o),   0);
        rst = 1'b0;
        tick(5);
        clr_mon();
        pulse_start();
        wait_done("restart done", 3000);
        chk("restart beats", beats.size(), 1);
        chk("restart value", beats.size() > 0 ? int'(beats[0]) : -1, 800);
        chk("restart from 0", addr_err, 0);
        chk("restart reads", rd_cnt, DEPTH);

        // start during SCAN is ignored
        clr_mon();
        pulse_start();
        tick(10);
        pulse_start();
        wait_done("scan start done", 3000);
        chk("scan start reads", rd_cnt, DEPTH);
        chk("scan start order", addr_err, 0);
        chk("scan start pulses", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
